// File: rtl/seg7_pkg.sv
// Shared constants and types for the four-digit seven-segment display driver.
package seg7_pkg;

  // Active-low segment patterns {dp,g,f,e,d,c,b,a}; dp is always off.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Wrap-blink sequencer states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BLINK_OFF = 2'd1,
    BLINK_ON  = 2'd2
  } blink_state_t;

  // 0.5 s half-period at 50 MHz, three off/on pairs per wrap.
  localparam int unsigned DEF_BLINK_TICKS = 25_000_000;
  localparam int unsigned DEF_BLINK_COUNT = 3;

endpackage

// File: rtl/seg7_display_driver_bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment decoder; 10..15 show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] seg
);

  // Look up the segment pattern for one digit.
  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_display_driver.sv
// Four-digit seven-segment driver: two-stage digit pipeline, leading-zero
// blanking, PWM brightness and a blink sequence on 9999 -> 0000 wrap.
module seg7_display_driver
  import seg7_pkg::*;
#(
  parameter int unsigned BLINK_TICKS = DEF_BLINK_TICKS,
  parameter int unsigned BLINK_COUNT = DEF_BLINK_COUNT,
  parameter int unsigned PWM_BITS    = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [3:0]          i_units,
  input  logic [3:0]          i_tens,
  input  logic [3:0]          i_hundreds,
  input  logic [3:0]          i_thousands,
  input  logic                i_blank_lz,
  input  logic [PWM_BITS-1:0] i_bright,
  output logic [7:0]          o_hex0,
  output logic [7:0]          o_hex1,
  output logic [7:0]          o_hex2,
  output logic [7:0]          o_hex3,
  output logic                o_blinking
);

  localparam int unsigned TICK_W = $clog2(BLINK_TICKS + 1);
  localparam int unsigned PAIR_W = $clog2(BLINK_COUNT + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BLINK_TICKS - 1);
  localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'(BLINK_COUNT);

  logic [15:0]         r_dig;
  logic [15:0]         r_prev;
  logic [PWM_BITS-1:0] pwm_cnt;
  blink_state_t        state, state_n;
  logic [TICK_W-1:0]   tick_cnt, tick_n;
  logic [PAIR_W-1:0]   pair_cnt, pair_n, pair_inc;
  logic [7:0]          seg0, seg1, seg2, seg3;
  logic                wrap_evt;
  logic                blank1, blank2, blank3;
  logic                force_off;

  // Stage 1: capture the digits and keep the previous capture for wrap detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dig  <= '0;
      r_prev <= '0;
    end else begin
      r_dig  <= {i_thousands, i_hundreds, i_tens, i_units};
      r_prev <= r_dig;
    end
  end

  bcd_to_seg7 u_dec0 (.digit(r_dig[3:0]),   .seg(seg0));
  bcd_to_seg7 u_dec1 (.digit(r_dig[7:4]),   .seg(seg1));
  bcd_to_seg7 u_dec2 (.digit(r_dig[11:8]),  .seg(seg2));
  bcd_to_seg7 u_dec3 (.digit(r_dig[15:12]), .seg(seg3));

  assign wrap_evt = (r_prev == 16'h9999) && (r_dig == 16'h0000);

  // Leading-zero masks and the whole-display off condition for this cycle.
  always_comb begin
    blank3    = i_blank_lz && (r_dig[15:12] == 4'd0);
    blank2    = blank3 && (r_dig[11:8] == 4'd0);
    blank1    = blank2 && (r_dig[7:4] == 4'd0);
    force_off = (state == BLINK_OFF) || (pwm_cnt >= i_bright);
  end

  // Free-running brightness counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Stage 2: register the decoded, masked patterns.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_hex0 <= SEG_BLANK;
      o_hex1 <= SEG_BLANK;
      o_hex2 <= SEG_BLANK;
      o_hex3 <= SEG_BLANK;
    end else begin
      o_hex0 <= force_off           ? SEG_BLANK : seg0;
      o_hex1 <= (force_off || blank1) ? SEG_BLANK : seg1;
      o_hex2 <= (force_off || blank2) ? SEG_BLANK : seg2;
      o_hex3 <= (force_off || blank3) ? SEG_BLANK : seg3;
    end
  end

  // Blink sequencer state, counters and registered busy flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      pair_cnt   <= '0;
      o_blinking <= 1'b0;
    end else begin
      state      <= state_n;
      tick_cnt   <= tick_n;
      pair_cnt   <= pair_n;
      o_blinking <= (state_n != IDLE);
    end
  end

  // Blink sequencer next state; a wrap anywhere restarts the full sequence.
  always_comb begin
    state_n  = state;
    tick_n   = tick_cnt + 1'b1;
    pair_n   = pair_cnt;
    pair_inc = pair_cnt + 1'b1;
    case (state)
      IDLE: begin
        tick_n = '0;
        pair_n = '0;
      end
      BLINK_OFF: begin
        if (tick_cnt == TICK_LAST) begin
          state_n = BLINK_ON;
          tick_n  = '0;
        end
      end
      BLINK_ON: begin
        if (tick_cnt == TICK_LAST) begin
          tick_n = '0;
          pair_n = pair_inc;
          if (pair_inc == PAIR_LAST) begin
            state_n = IDLE;
            pair_n  = '0;
          end else begin
            state_n = BLINK_OFF;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tick_n  = '0;
        pair_n  = '0;
      end
    endcase
    if (wrap_evt) begin
      state_n = BLINK_OFF;
      tick_n  = '0;
      pair_n  = '0;
    end
  end

endmodule

// File: tb/tb_seg7_display_driver.sv
// Directed self-checking bench for seg7_display_driver (BLINK_TICKS=4, BLINK_COUNT=2).
module tb_seg7_display_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] units = '0, tens = '0, hundreds = '0, thousands = '0;
  logic       blank_lz = 1'b0;
  logic [3:0] bright = '0;
  logic [7:0] hex0, hex1, hex2, hex3;
  logic       blinking;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference brightness phase: en_m is 1 when the current outputs were registered
  // in an enabled PWM phase.
  logic [3:0] pwm_m;
  logic       en_m;

  seg7_display_driver #(.BLINK_TICKS(4), .BLINK_COUNT(2), .PWM_BITS(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_units(units), .i_tens(tens), .i_hundreds(hundreds), .i_thousands(thousands),
    .i_blank_lz(blank_lz), .i_bright(bright),
    .o_hex0(hex0), .o_hex1(hex1), .o_hex2(hex2), .o_hex3(hex3),
    .o_blinking(blinking)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_m <= '0;
      en_m  <= 1'b0;
    end else begin
      pwm_m <= pwm_m + 4'd1;
      en_m  <= (pwm_m < bright);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_digits(input logic [15:0] d);
    {thousands, hundreds, tens, units} = d;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    n_checks++;
    if ({hex3, hex2, hex1, hex0} !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL reset_hex: got %h expected ffffffff", {hex3, hex2, hex1, hex0});
    end
    n_checks++;
    if (blinking !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_blinking: got %b expected 0", blinking);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_decode();
    int unsigned n_off = 0;
    bright = 4'd15; blank_lz = 1'b0;
    set_digits(16'h1234);
    step(); step();
    for (int i = 0; i < 16; i++) begin
      logic [31:0] exp;
      exp = en_m ? 32'hF9A4_B099 : 32'hFFFF_FFFF;
      if (!en_m) n_off++;
      n_checks++;
      if ({hex3, hex2, hex1, hex0} !== exp) begin
        n_fail++;
        $display("FAIL decode_1234 cyc%0d: got %h expected %h", i, {hex3, hex2, hex1, hex0}, exp);
      end
      n_checks++;
      if (blinking !== 1'b0) begin
        n_fail++;
        $display("FAIL decode_blinking cyc%0d: got %b expected 0", i, blinking);
      end
      step();
    end
    n_checks++;
    if (n_off != 1) begin
      n_fail++;
      $display("FAIL decode_off_phases: got %0d expected 1", n_off);
    end
  endtask

  task automatic test_blank_lz();
    bright = 4'd15; blank_lz = 1'b1;
    set_digits(16'h0050);
    step(); step();
    for (int i = 0; i < 16; i++) begin
      logic [31:0] exp;
      exp = en_m ? 32'hFFFF_92C0 : 32'hFFFF_FFFF;
      n_checks++;
      if ({hex3, hex2, hex1, hex0} !== exp) begin
        n_fail++;
        $display("FAIL blank_0050 cyc%0d: got %h expected %h", i, {hex3, hex2, hex1, hex0}, exp);
      end
      step();
    end
    set_digits(16'h0000);
    step(); step();
    for (int i = 0; i < 16; i++) begin
      logic [31:0] exp;
      exp = en_m ? 32'hFFFF_FFC0 : 32'hFFFF_FFFF;
      n_checks++;
      if ({hex3, hex2, hex1, hex0} !== exp) begin
        n_fail++;
        $display("FAIL blank_0000 cyc%0d: got %h expected %h", i, {hex3, hex2, hex1, hex0}, exp);
      end
      step();
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_pwm();
    int unsigned n_on = 0, n_ff = 0;
    set_digits(16'h8888);
    bright = 4'd4;
    step(); step(); step();
    for (int i = 0; i < 16; i++) begin
      if ({hex3, hex2, hex1, hex0} === 32'h8080_8080) n_on++;
      if ({hex3, hex2, hex1, hex0} === 32'hFFFF_FFFF) n_ff++;
      step();
    end
    n_checks++;
    if (n_on != 4) begin
      n_fail++;
      $display("FAIL pwm4_on_count: got %0d expected 4", n_on);
    end
    n_checks++;
    if (n_ff != 12) begin
      n_fail++;
      $display("FAIL pwm4_off_count: got %0d expected 12", n_ff);
    end
    bright = 4'd0;
    step(); step();
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if ({hex3, hex2, hex1, hex0} !== 32'hFFFF_FFFF) begin
        n_fail++;
        $display("FAIL pwm0_dark cyc%0d: got %h expected ffffffff", i, {hex3, hex2, hex1, hex0});
      end
      step();
    end
    bright = 4'd15;
  endtask

  // k counts edges after the one that captured 0000 over a held 9999.
  task automatic test_wrap_blink();
    bright = 4'd15;
    set_digits(16'h9999);
    step(); step(); step();
    set_digits(16'h0000);
    step();
    n_checks++;
    if (blinking !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_k0_blinking: got %b expected 0", blinking);
    end
    for (int k = 1; k <= 20; k++) begin
      logic [31:0] exp;
      logic        exp_b;
      step();
      exp_b = (k <= 16);
      if ((k >= 2 && k <= 5) || (k >= 10 && k <= 13) || !en_m) exp = 32'hFFFF_FFFF;
      else exp = 32'hC0C0_C0C0;
      n_checks++;
      if ({hex3, hex2, hex1, hex0} !== exp) begin
        n_fail++;
        $display("FAIL wrap_hex k%0d: got %h expected %h", k, {hex3, hex2, hex1, hex0}, exp);
      end
      n_checks++;
      if (blinking !== exp_b) begin
        n_fail++;
        $display("FAIL wrap_blinking k%0d: got %b expected %b", k, blinking, exp_b);
      end
    end
  endtask

  task automatic test_no_wrap_and_dash();
    set_digits(16'h1234);
    step(); step(); step();
    set_digits(16'h0000);
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (blinking !== 1'b0) begin
        n_fail++;
        $display("FAIL nowrap_blinking cyc%0d: got %b expected 0", i, blinking);
      end
    end
    set_digits(16'h000C);
    step(); step();
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp;
      exp = en_m ? 8'hBF : 8'hFF;
      n_checks++;
      if (hex0 !== exp) begin
        n_fail++;
        $display("FAIL dash_hex0 cyc%0d: got %h expected %h", i, hex0, exp);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    bright = 4'd15;
    set_digits(16'h9999);
    step(); step(); step();
    set_digits(16'h0000);
    step();
    for (int k = 1; k <= 5; k++) step();
    // In BLINK_ON: present 9999 then 0000 to raise a second wrap.
    set_digits(16'h9999);
    step();
    set_digits(16'h0000);
    step();
    for (int k = 1; k <= 20; k++) begin
      logic [31:0] exp;
      logic        exp_b;
      step();
      exp_b = (k <= 16);
      if ((k >= 2 && k <= 5) || (k >= 10 && k <= 13) || !en_m) exp = 32'hFFFF_FFFF;
      else exp = 32'hC0C0_C0C0;
      n_checks++;
      if ({hex3, hex2, hex1, hex0} !== exp) begin
        n_fail++;
        $display("FAIL rewrap_hex k%0d: got %h expected %h", k, {hex3, hex2, hex1, hex0}, exp);
      end
      n_checks++;
      if (blinking !== exp_b) begin
        n_fail++;
        $display("FAIL rewrap_blinking k%0d: got %b expected %b", k, blinking, exp_b);
      end
    end
  endtask

  task automatic test_reset_mid_blink();
    bright = 4'd15;
    set_digits(16'h9999);
    step(); step(); step();
    set_digits(16'h0000);
    step();
    step(); step(); step();
    n_checks++;
    if (blinking !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre_blinking: got %b expected 1", blinking);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({hex3, hex2, hex1, hex0} !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL midrst_hex: got %h expected ffffffff", {hex3, hex2, hex1, hex0});
    end
    n_checks++;
    if (blinking !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_blinking: got %b expected 0", blinking);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++;
      if (blinking !== 1'b0) begin
        n_fail++;
        $display("FAIL postrst_blinking cyc%0d: got %b expected 0", i, blinking);
      end
    end
    step();
    n_checks++;
    if ({hex3, hex2, hex1, hex0} !== (en_m ? 32'hC0C0_C0C0 : 32'hFFFF_FFFF)) begin
      n_fail++;
      $display("FAIL postrst_hex: got %h expected %h", {hex3, hex2, hex1, hex0},
               en_m ? 32'hC0C0_C0C0 : 32'hFFFF_FFFF);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_blank_lz();
    test_pwm();
    test_wrap_blink();
    test_no_wrap_and_dash();
    test_back_to_back();
    test_reset_mid_blink();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
